i2s_rx_param: RTL and testbench



---
 rtl/i2s_pkg.sv | 32 +++
 rtl/i2s_clkgen.sv | 98 +++++++++
 rtl/i2s_rx_param.sv | 128 ++++++++++++
 tb/tb_i2s_rx_param.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receiver/transmitter family.
//   JUSTIFY_I2S / JUSTIFY_LJ : framing selectors
//   frame_len()              : clk cycles per stereo frame
//   data_delay()             : SCK periods between a ws edge and the MSB
//   clk_div_ok() / cfg_ok()  : parameter legality, used by elaboration checks
package i2s_pkg;

  localparam int JUSTIFY_I2S = 0;
  localparam int JUSTIFY_LJ  = 1;

  function automatic int frame_len(input int slot_w, input int clk_div);
    return 2 * slot_w * clk_div;
  endfunction

  function automatic int data_delay(input int justify);
    return (justify == JUSTIFY_I2S) ? 1 : 0;
  endfunction

  function automatic bit clk_div_ok(input int clk_div);
    return (clk_div >= 4) && ((clk_div % 2) == 0);
  endfunction

  // DATA_W >= 2 keeps the shift-register slice expression well formed.
  function automatic bit cfg_ok(input int data_w, input int slot_w,
                                input int clk_div, input int justify);
    return clk_div_ok(clk_div) &&
           ((justify == JUSTIFY_I2S) || (justify == JUSTIFY_LJ)) &&
           (data_w >= 2) &&
           ((data_w + data_delay(justify)) <= slot_w);
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S master clock generator: serial bit clock, word select and the
// bit-position bookkeeping shared by the receiver and the transmitter.
//   clk, rst     : system clock, asynchronous active-high reset
//   i_en         : level enable; low holds everything at zero
//   o_sck        : serial bit clock (high for the second half of a period)
//   o_ws         : word select, 0 = left slot, 1 = right slot
//   o_cap_stb    : high in the cycle whose closing edge raises o_sck
//   o_frame_end  : high in the last clk cycle of a stereo frame
//   o_bit_cnt    : SCK period index within the frame, 0..2*SLOT_W-1
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int SLOT_W  = 32,
  parameter int CLK_DIV = 28
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_en,
  output logic                        o_sck,
  output logic                        o_ws,
  output logic                        o_cap_stb,
  output logic                        o_frame_end,
  output logic [$clog2(2*SLOT_W)-1:0] o_bit_cnt
);

  localparam int SCW = $clog2(CLK_DIV);
  localparam int BW  = $clog2(2 * SLOT_W);

  localparam logic [SCW-1:0] SCK_LAST = SCW'(CLK_DIV - 1);
  localparam logic [SCW-1:0] SCK_HALF = SCW'(CLK_DIV / 2);
  localparam logic [SCW-1:0] SCK_CAP  = SCW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0]  BIT_LAST = BW'(2 * SLOT_W - 1);
  localparam logic [BW-1:0]  SLOT_N   = BW'(SLOT_W);

  if (!clk_div_ok(CLK_DIV)) begin : g_bad_clk_div
    $error("i2s_clkgen: CLK_DIV must be even and at least 4");
  end

  // r_run distinguishes the first enabled edge (counters held at zero)
  // from the following ones, so a frame starts from a full count of zero.
  logic           r_run;
  logic [SCW-1:0] r_sck_cnt;
  logic [BW-1:0]  r_bit_cnt;
  logic           r_sck;
  logic           r_ws;

  logic           w_sck_last;
  logic           w_bit_last;
  logic [SCW-1:0] w_sck_nxt;
  logic [BW-1:0]  w_bit_nxt;

  assign w_sck_last = (r_sck_cnt == SCK_LAST);
  assign w_bit_last = (r_bit_cnt == BIT_LAST);

  always_comb begin
    w_sck_nxt = r_sck_cnt;
    w_bit_nxt = r_bit_cnt;
    if (r_run) begin
      if (w_sck_last) begin
        w_sck_nxt = '0;
        w_bit_nxt = w_bit_last ? '0 : r_bit_cnt + 1'b1;
      end else begin
        w_sck_nxt = r_sck_cnt + 1'b1;
      end
    end
  end

  // sck/ws are decoded from the next counter values and registered, so the
  // pins are glitch-free yet track the counters cycle for cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run     <= 1'b0;
      r_sck_cnt <= '0;
      r_bit_cnt <= '0;
      r_sck     <= 1'b0;
      r_ws      <= 1'b0;
    end else if (!i_en) begin
      r_run     <= 1'b0;
      r_sck_cnt <= '0;
      r_bit_cnt <= '0;
      r_sck     <= 1'b0;
      r_ws      <= 1'b0;
    end else begin
      r_run     <= 1'b1;
      r_sck_cnt <= w_sck_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_sck     <= (w_sck_nxt >= SCK_HALF);
      r_ws      <= (w_bit_nxt >= SLOT_N);
    end
  end

  assign o_sck       = r_sck;
  assign o_ws        = r_ws;
  assign o_cap_stb   = r_run && (r_sck_cnt == SCK_CAP);
  assign o_frame_end = r_run && w_sck_last && w_bit_last;
  assign o_bit_cnt   = r_bit_cnt;

endmodule

// File: rtl/i2s_rx_param.sv
// Parametrised I2S master receiver. Generates mic_sck/mic_ws, deserialises
// one stereo frame per 2*SLOT_W SCK periods and presents it on a valid/ready
// port.
//   clk, rst             : system clock, asynchronous active-high reset
//   en                   : level enable; low discards the frame in progress
//                          and any pending output frame
//   mic_sck, mic_ws      : serial bit clock and word select (0 = left)
//   mic_sd               : serial data, MSB first
//   out_valid/out_ready  : output handshake. A frame transfers on every edge
//                          where both are high; while valid is high and not
//                          accepted, out_ldata/out_rdata hold steady. A new
//                          frame arriving while one is still unaccepted
//                          replaces it and pulses overrun for one cycle.
//   out_ldata, out_rdata : captured left/right samples, DATA_W bits verbatim
//   overrun              : one-cycle overwrite indication
module i2s_rx_param
  import i2s_pkg::*;
#(
  parameter int DATA_W  = 24,
  parameter int SLOT_W  = 32,
  parameter int CLK_DIV = 28,
  parameter int JUSTIFY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              mic_sck,
  output logic              mic_ws,
  input  logic              mic_sd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ldata,
  output logic [DATA_W-1:0] out_rdata,
  output logic              overrun
);

  localparam int D  = data_delay(JUSTIFY);
  localparam int BW = $clog2(2 * SLOT_W);

  localparam logic [BW-1:0] SLOT_N = BW'(SLOT_W);
  localparam logic [BW-1:0] WIN_LO = BW'(D);
  localparam logic [BW-1:0] WIN_N  = BW'(DATA_W);

  if (!cfg_ok(DATA_W, SLOT_W, CLK_DIV, JUSTIFY)) begin : g_bad_cfg
    $error("i2s_rx_param: illegal DATA_W/SLOT_W/CLK_DIV/JUSTIFY combination");
  end

  logic          w_ws;
  logic          w_cap_stb;
  logic          w_frame_end;
  logic [BW-1:0] w_bit_cnt;
  logic [BW-1:0] w_slot;
  logic [BW-1:0] w_rel;
  logic          w_in_win;

  logic [DATA_W-1:0] r_shift_l;
  logic [DATA_W-1:0] r_shift_r;
  logic [DATA_W-1:0] r_ldata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_valid;
  logic              r_overrun;

  i2s_clkgen #(
    .SLOT_W  (SLOT_W),
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk         (clk),
    .rst         (rst),
    .i_en        (en),
    .o_sck       (mic_sck),
    .o_ws        (w_ws),
    .o_cap_stb   (w_cap_stb),
    .o_frame_end (w_frame_end),
    .o_bit_cnt   (w_bit_cnt)
  );

  assign mic_ws = w_ws;

  // Position inside the current channel slot. Subtracting WIN_LO wraps
  // positions before the window to large values, so one compare against
  // DATA_W bounds the window on both sides.
  assign w_slot   = w_ws ? (w_bit_cnt - SLOT_N) : w_bit_cnt;
  assign w_rel    = w_slot - WIN_LO;
  assign w_in_win = (w_rel < WIN_N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift_l <= '0;
      r_shift_r <= '0;
      r_ldata   <= '0;
      r_rdata   <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (!en) begin
      r_shift_l <= '0;
      r_shift_r <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_frame_end) begin
      // The capture strobe never falls in the last clk cycle of a period,
      // so no data bit is lost to this branch.
      r_ldata   <= r_shift_l;
      r_rdata   <= r_shift_r;
      r_valid   <= 1'b1;
      r_overrun <= r_valid && !out_ready;
      r_shift_l <= '0;
      r_shift_r <= '0;
    end else begin
      r_overrun <= 1'b0;
      if (w_cap_stb && w_in_win) begin
        if (!w_ws) begin
          r_shift_l <= {r_shift_l[DATA_W-2:0], mic_sd};
        end else begin
          r_shift_r <= {r_shift_r[DATA_W-2:0], mic_sd};
        end
      end
      if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_ldata = r_ldata;
  assign out_rdata = r_rdata;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_i2s_rx_param.sv
// Bench for i2s_rx_param: an I2S-framed 24-bit instance and a left-justified
// 16-bit instance run side by side from shared en/rst/out_ready, each fed by
// its own microphone model.
module tb_i2s_rx_param;

  localparam int SLOT_W  = 32;
  localparam int CLK_DIV = 8;
  localparam int FL      = 2 * SLOT_W * CLK_DIV;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst, en, out_ready;
  logic [1:0] sd;

  logic        sck0, ws0, v0, o0;
  logic [23:0] l0, r0;
  logic        sck1, ws1, v1, o1;
  logic [15:0] l1, r1;

  always #5 clk = ~clk;

  i2s_rx_param #(.DATA_W(24), .SLOT_W(SLOT_W), .CLK_DIV(CLK_DIV), .JUSTIFY(0)) u_dut_i2s (
    .clk(clk), .rst(rst), .en(en), .mic_sck(sck0), .mic_ws(ws0), .mic_sd(sd[0]),
    .out_valid(v0), .out_ready(out_ready), .out_ldata(l0), .out_rdata(r0), .overrun(o0)
  );

  i2s_rx_param #(.DATA_W(16), .SLOT_W(SLOT_W), .CLK_DIV(CLK_DIV), .JUSTIFY(1)) u_dut_lj (
    .clk(clk), .rst(rst), .en(en), .mic_sck(sck1), .mic_ws(ws1), .mic_sd(sd[1]),
    .out_valid(v1), .out_ready(out_ready), .out_ldata(l1), .out_rdata(r1), .overrun(o1)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;   // posedges seen
  int run_cyc  = -1;  // clk cycles since the first enabled edge, -1 when idle
  bit en_e     = 1'b0; // enable as applied at the most recent edge
  bit use_fixed = 1'b0;
  int ovr_cnt  = 0;
  int coinc_cnt = 0;

  logic [23:0] cur_l[2];
  logic [23:0] cur_r[2];
  // {due_cycle[31:0], l0[23:0], r0[23:0], l1[15:0], r1[15:0]}
  logic [111:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] rand_smp(input int d);
    return (d == 0) ? 24'($urandom) : {8'h00, 16'($urandom)};
  endfunction

  // Microphone model: what a mic puts on SD in frame bit position pos.
  // I2S instance: MSB one period after the ws edge, random outside the word.
  // LJ instance: MSB on the ws edge, ones outside the word.
  function automatic logic model_bit(input int d, input logic [23:0] l,
                                     input logic [23:0] r, input int pos);
    int dw, dly, s;
    logic [23:0] smp;
    dw  = (d == 0) ? 24 : 16;
    dly = (d == 0) ? 1 : 0;
    s   = pos % SLOT_W;
    smp = (pos >= SLOT_W) ? r : l;
    if (s >= dly && s < dly + dw) return smp[dw - 1 - (s - dly)];
    return (d == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // ---------------- reference timeline + scoreboard producer ----------------
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst || !en) begin
      run_cyc = -1;
      en_e    = 1'b0;
    end else begin
      en_e = 1'b1;
      run_cyc++;
      if (run_cyc % FL == 0) begin
        if (run_cyc > 0)
          exp_q.push_back({32'(cyc), cur_l[0], cur_r[0], cur_l[1][15:0], cur_r[1][15:0]});
        if (use_fixed) begin
          cur_l[0] = 24'hA5C3F1; cur_r[0] = 24'h123456;
          cur_l[1] = 24'h008001; cur_r[1] = 24'h007FFE;
          use_fixed = 1'b0;
        end else begin
          for (int d = 0; d < 2; d++) begin
            cur_l[d] = rand_smp(d);
            cur_r[d] = rand_smp(d);
          end
        end
      end
    end
  end

  // ---------------- serial data driver ----------------
  // A new bit goes out at the start of each SCK period (just after sck falls).
  initial forever begin
    @(negedge clk);
    if (run_cyc >= 0 && run_cyc % CLK_DIV == 0) begin
      for (int d = 0; d < 2; d++)
        sd[d] = model_bit(d, cur_l[d], cur_r[d], (run_cyc / CLK_DIV) % (2 * SLOT_W));
    end
  end

  // ---------------- monitor ----------------
  bit          pv[2];
  bit          pa[2];
  logic [23:0] pl[2];
  logic [23:0] pr[2];

  initial forever begin
    bit          mv[2], mo[2], ms[2], mw[2], ld[2];
    logic [23:0] ml[2], mr[2];
    logic [111:0] e;
    bit exp_sck, exp_ws;
    @(negedge clk);
    #1;
    mv[0] = v0; mo[0] = o0; ms[0] = sck0; mw[0] = ws0; ml[0] = l0; mr[0] = r0;
    mv[1] = v1; mo[1] = o1; ms[1] = sck1; mw[1] = ws1; ml[1] = {8'h00, l1}; mr[1] = {8'h00, r1};
    if (rst) begin
      for (int d = 0; d < 2; d++) begin pv[d] = 1'b0; pa[d] = 1'b0; end
      continue;
    end
    if (exp_q.size() > 0 && int'(exp_q[0][111:80]) < cyc) begin
      n_checks++; n_fail++;
      $display("FAIL frame_timeout: frame due at cycle %0d not presented, now %0d",
               exp_q[0][111:80], cyc);
      void'(exp_q.pop_front());
    end
    exp_sck = (run_cyc % CLK_DIV) >= (CLK_DIV / 2);
    exp_ws  = ((run_cyc / CLK_DIV) % (2 * SLOT_W)) >= SLOT_W;
    for (int d = 0; d < 2; d++) begin
      ld[d] = 1'b0;
      if (!en_e) begin
        check($sformatf("dut%0d_idle{sck,ws,valid,ovr}", d), {ms[d], mw[d], mv[d], mo[d]}, 4'b0000);
        mv[d] = 1'b0;
      end else begin
        check($sformatf("dut%0d_{sck,ws}", d), {ms[d], mw[d]}, {exp_sck, exp_ws});
        ld[d] = (mv[d] && !pv[d]) || mo[d] || (pa[d] && mv[d]);
        if (ld[d]) begin
          check($sformatf("dut%0d_overrun", d), mo[d], pv[d] && !pa[d]);
          if (mo[d]) ovr_cnt++;
          if (pa[d]) coinc_cnt++;
        end else if (pa[d]) begin
          check($sformatf("dut%0d_valid_drop", d), mv[d], 1'b0);
        end else if (pv[d]) begin
          check($sformatf("dut%0d_hold{v,l,r}", d), {mv[d], ml[d], mr[d]}, {1'b1, pl[d], pr[d]});
        end
      end
    end
    if (ld[0] || ld[1]) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_frame: dut0 l=%0h r=%0h, dut1 l=%0h r=%0h, none expected",
                 ml[0], mr[0], ml[1], mr[1]);
      end else begin
        e = exp_q.pop_front();
        check("frame_cycle", cyc, e[111:80]);
        check("dut0_frame{present,l,r}", {ld[0], ml[0], mr[0]}, {1'b1, e[79:56], e[55:32]});
        check("dut1_frame{present,l,r}", {ld[1], ml[1][15:0], mr[1][15:0]}, {1'b1, e[31:16], e[15:0]});
      end
    end
    for (int d = 0; d < 2; d++) begin
      pv[d] = mv[d];
      pa[d] = mv[d] && out_ready;
      pl[d] = ml[d];
      pr[d] = mr[d];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_zero(input string tag);
    check({tag, "_dut0"}, {sck0, ws0, v0, o0, l0, r0}, 52'd0);
    check({tag, "_dut1"}, {sck1, ws1, v1, o1, l1, r1}, 36'd0);
  endtask

  task automatic wait_run_pos(input int p);
    bit hit = 1'b0;
    for (int i = 0; i < 2 * FL && !hit; i++) begin
      @(negedge clk);
      #1;
      if (run_cyc >= 0 && run_cyc % FL == p) hit = 1'b1;
    end
    if (!hit) check($sformatf("wait_frame_pos_%0d", p), 0, 1);
  endtask

  // t0 is the cycle count just before the first enabled edge.
  task automatic wait_first_valid(input int t0, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < FL + 32 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (v0 && v1) hit = 1'b1;
    end
    check(name, cyc - (t0 + 1), FL);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    rst = 1'b1; en = 1'b0; out_ready = 1'b0; sd = 2'b00;
    for (int d = 0; d < 2; d++) begin cur_l[d] = '0; cur_r[d] = '0; end
    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst = 1'b0;

    // idle: en low for 1000 cycles, monitor checks each one
    repeat (1000) @(negedge clk);

    // first frame with known values, then free-running random frames
    use_fixed = 1'b1; out_ready = 1'b1; en = 1'b1; t0 = cyc;
    wait_first_valid(t0, "first_frame_latency");
    check("i2s_ldata", l0, 24'hA5C3F1);
    check("i2s_rdata", r0, 24'h123456);
    check("lj_ldata", l1, 16'h8001);
    check("lj_rdata", r1, 16'h7FFE);
    repeat (2 * FL) @(negedge clk);

    // backpressure across two frame ends
    wait_run_pos(4);
    @(negedge clk) out_ready = 1'b0;
    repeat (2 * FL) @(negedge clk);
    check("overrun_seen", ovr_cnt > 0, 1'b1);
    out_ready = 1'b1;
    repeat (FL / 2) @(negedge clk);

    // random ready
    for (int i = 0; i < 3 * FL; i++) begin
      @(negedge clk) out_ready = 1'($urandom_range(0, 1));
    end

    // accept exactly on the frame-end edge while a frame is pending
    @(negedge clk) out_ready = 1'b0;
    wait_run_pos(FL / 4);
    wait_run_pos(FL - 2);
    @(negedge clk) out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("coincident_accept_seen", coinc_cnt > 0, 1'b1);
    out_ready = 1'b1;
    repeat (FL) @(negedge clk);

    // en drop at bit 40, re-enable 300 cycles later
    wait_run_pos(40 * CLK_DIV);
    @(negedge clk) en = 1'b0;
    repeat (300) @(negedge clk);
    en = 1'b1; t0 = cyc;
    wait_first_valid(t0, "reenable_latency");
    repeat (FL) @(negedge clk);

    // asynchronous reset mid-frame
    wait_run_pos(200);
    @(negedge clk) rst = 1'b1;
    #1 check_zero("midframe_reset");
    repeat (3) @(negedge clk);
    rst = 1'b0; t0 = cyc;
    wait_first_valid(t0, "post_reset_latency");
    repeat (FL) @(negedge clk);

    @(negedge clk) en = 1'b0;
    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
